// File: rtl/lru_arbiter.sv
// lru_arbiter: round-robin front end that shares one set-associative LRU engine among NUM_REQ requesters.
// Optional per-kind operation counters are enabled by defining LRU_ARB_STATS_EN.
module lru_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WAY         = 4,
  parameter int SET_INDEX_W = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [2*NUM_REQ-1:0]           req_kind,
  input  logic [NUM_REQ*SET_INDEX_W-1:0] req_index,
  input  logic [5*NUM_REQ-1:0]           req_way,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [4:0]                     rsp_way,
  output logic                           busy,
  output logic                           lru_start,
  output logic                           lru_found_in_cache,
  output logic                           lru_updated,
  output logic                           lru_replace,
  output logic [SET_INDEX_W-1:0]         lru_index,
  output logic [4:0]                     lru_way_index,
  input  logic [4:0]                     lru_replace_index,
  input  logic                           lru_block_replace,
  output logic [2:0]                     state_dbg
`ifdef LRU_ARB_STATS_EN
  ,
  output logic [31:0]                    hit_cnt,
  output logic [31:0]                    fill_cnt,
  output logic [31:0]                    repl_cnt
`endif
);

  // Handshake: req is a level held until its rsp_valid; gnt and rsp_valid are
  // one-cycle one-hot pulses, and requests are only looked at while in IDLE.
  typedef enum logic [2:0] {
    S_DRAIN = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(WAY + 3);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(WAY + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAY);

  state_t                 state, state_nx;
  logic [PTR_W-1:0]       rr_ptr, rr_nx;
  logic [CNT_W-1:0]       cnt;
  logic [PTR_W-1:0]       op_sel;
  logic [1:0]             op_kind;
  logic [SET_INDEX_W-1:0] op_index;
  logic [4:0]             op_way;
  logic [4:0]             victim;
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic                   op_is_fill, op_is_repl, op_is_hit;

  assign state_dbg  = state;
  assign op_is_fill = (op_kind == 2'b01);
  assign op_is_repl = (op_kind == 2'b10);
  assign op_is_hit  = !op_is_fill && !op_is_repl;

  // First requesting index at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
    rr_nx = PTR_W'((int'(win_idx) + 1) % NUM_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_DRAIN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_DRAIN: if (cnt == DRAIN_LAST) state_nx = S_IDLE;
      S_IDLE:  if (win_found) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (cnt == WAIT_LAST) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      cnt      <= '0;
      op_sel   <= '0;
      op_kind  <= '0;
      op_index <= '0;
      op_way   <= '0;
      victim   <= '0;
    end else begin
      case (state)
        S_DRAIN: cnt <= (cnt == DRAIN_LAST) ? '0 : cnt + 1'b1;
        S_IDLE: begin
          if (win_found) begin
            op_sel   <= win_idx;
            op_kind  <= req_kind[2*int'(win_idx) +: 2];
            op_index <= req_index[int'(win_idx)*SET_INDEX_W +: SET_INDEX_W];
            op_way   <= req_way[5*int'(win_idx) +: 5];
            rr_ptr   <= rr_nx;
            victim   <= '0;
          end
        end
        S_WAIT: begin
          cnt <= (cnt == WAIT_LAST) ? '0 : cnt + 1'b1;
          // Engine reports a 0-based victim; requesters see 1-based ways.
          if (lru_block_replace) victim <= lru_replace_index + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Engine flags are sticky on its side, so they are asserted only in ISSUE.
  always_comb begin
    gnt                = '0;
    rsp_valid          = '0;
    rsp_way            = '0;
    busy               = 1'b1;
    lru_start          = 1'b0;
    lru_found_in_cache = 1'b0;
    lru_updated        = 1'b0;
    lru_replace        = 1'b0;
    lru_index          = '0;
    lru_way_index      = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (win_found) gnt[win_idx] = 1'b1;
      end
      S_ISSUE: begin
        lru_start          = 1'b1;
        lru_found_in_cache = op_is_hit;
        lru_updated        = op_is_fill;
        lru_replace        = op_is_repl;
        lru_index          = op_index;
        lru_way_index      = op_way;
      end
      S_WAIT: begin
        lru_index     = op_index;
        lru_way_index = op_way;
      end
      S_RESP: begin
        rsp_valid[op_sel] = 1'b1;
        rsp_way           = op_is_repl ? victim : op_way;
      end
      default: ;
    endcase
  end

`ifdef LRU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      fill_cnt <= '0;
      repl_cnt <= '0;
    end else if (state == S_RESP) begin
      if (op_is_repl) begin
        if (repl_cnt != 32'hFFFF_FFFF) repl_cnt <= repl_cnt + 32'd1;
      end else if (op_is_fill) begin
        if (fill_cnt != 32'hFFFF_FFFF) fill_cnt <= fill_cnt + 32'd1;
      end else begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lru_arbiter.sv
// Bench for lru_arbiter: behavioural LRU engine, transaction scoreboard and directed plus random requests.
module tb_lru_arbiter;
  localparam int N   = 4;
  localparam int WAY = 4;
  localparam int SIW = 9;
  localparam int OCC = WAY + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [2*N-1:0]   req_kind;
  logic [N*SIW-1:0] req_index;
  logic [5*N-1:0]   req_way;
  logic [N-1:0]     gnt, rsp_valid;
  logic [4:0]       rsp_way;
  logic             busy;
  logic             lru_start, lru_found_in_cache, lru_updated, lru_replace;
  logic [SIW-1:0]   lru_index;
  logic [4:0]       lru_way_index;
  logic [4:0]       lru_replace_index;
  logic             lru_block_replace;
  logic [2:0]       state_dbg;
`ifdef LRU_ARB_STATS_EN
  logic [31:0]      hit_cnt, fill_cnt, repl_cnt;
`endif

  lru_arbiter #(.NUM_REQ(N), .WAY(WAY), .SET_INDEX_W(SIW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_kind(req_kind), .req_index(req_index),
    .req_way(req_way), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_way(rsp_way), .busy(busy),
    .lru_start(lru_start), .lru_found_in_cache(lru_found_in_cache),
    .lru_updated(lru_updated), .lru_replace(lru_replace), .lru_index(lru_index),
    .lru_way_index(lru_way_index), .lru_replace_index(lru_replace_index),
    .lru_block_replace(lru_block_replace), .state_dbg(state_dbg)
`ifdef LRU_ARB_STATS_EN
    , .hit_cnt(hit_cnt), .fill_cnt(fill_cnt), .repl_cnt(repl_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural LRU engine ----------------
  // ord[s][0] is the least recently used way of set s.
  int   ord [512][WAY];
  bit   eng_mute  = 1'b0;
  bit   eng_fired = 1'b0;
  logic [4:0] eng_victim = '0;

  task automatic touch(input int s, input int w0);
    int p = 0;
    for (int k = 0; k < WAY; k++) if (ord[s][k] == w0) p = k;
    for (int k = p; k < WAY - 1; k++) ord[s][k] = ord[s][k+1];
    ord[s][WAY-1] = w0;
  endtask

  initial begin
    int s, v;
    for (int a = 0; a < 512; a++) for (int k = 0; k < WAY; k++) ord[a][k] = k;
    lru_block_replace = 1'b0;
    lru_replace_index = '0;
    forever begin
      @(negedge clk);
      if (lru_start === 1'b1) begin
        s = int'(lru_index);
        eng_fired = 1'b0;
        if (lru_replace && !eng_mute) begin
          v = ord[s][0];
          touch(s, v);
          repeat (WAY + 1) @(posedge clk);
          #1;
          lru_replace_index = 5'(v);
          lru_block_replace = 1'b1;
          eng_fired  = 1'b1;
          eng_victim = 5'(v);
          @(posedge clk);
          #1;
          lru_block_replace = 1'b0;
          lru_replace_index = 5'($urandom_range(0, 31));
        end else if ((lru_found_in_cache || lru_updated) &&
                     lru_way_index >= 5'd1 && int'(lru_way_index) <= WAY) begin
          touch(s, int'(lru_way_index) - 1);
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic [31:0]    cyc;
    logic [1:0]     w;
    logic [1:0]     kind;
    logic [SIW-1:0] idx;
    logic [4:0]     way;
  } op_t;
  localparam int OP_W = $bits(op_t);

  logic [OP_W-1:0] exp_q[$];
  int gnt_log[$];
  int gnt_cyc_log[$];
  int cyc = 0, drain_left = 0, m_rr = 0;
  int m_hits = 0, m_fills = 0, m_repls = 0;

  initial begin
    int exp_w;
    logic [N-1:0] em;
    logic [4:0] ew;
    logic [2:0] ef;
    bit idle_now;
    op_t o, no;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst === 1'b1) begin
        exp_q.delete();
        m_rr = 0;
        drain_left = WAY + 2;
        m_hits = 0; m_fills = 0; m_repls = 0;
      end else begin
        idle_now = (drain_left == 0) && (exp_q.size() == 0);
        if (drain_left > 0) begin
          chk("drain_rsp", {rsp_valid, rsp_way}, 0);
          chk("drain_lru", {lru_start, lru_found_in_cache, lru_updated, lru_replace,
                            lru_index, lru_way_index}, 0);
          drain_left--;
        end
        exp_w = -1;
        if (idle_now)
          for (int k = 0; k < N; k++)
            if (exp_w < 0 && req[(m_rr + k) % N]) exp_w = (m_rr + k) % N;
        em = '0;
        if (exp_w >= 0) em[exp_w] = 1'b1;
        chk("gnt", gnt, em);
        chk("busy", busy, idle_now ? 0 : 1);
        if (!lru_start) chk("flags_idle", {lru_found_in_cache, lru_updated, lru_replace}, 0);
        if (exp_w >= 0) begin
          no.cyc  = cyc;
          no.w    = 2'(exp_w);
          no.kind = req_kind[2*exp_w +: 2];
          no.idx  = req_index[exp_w*SIW +: SIW];
          no.way  = req_way[5*exp_w +: 5];
          exp_q.push_back(no);
          m_rr = (exp_w + 1) % N;
          gnt_log.push_back(exp_w);
          gnt_cyc_log.push_back(cyc);
        end
        if (exp_q.size() != 0) begin
          o = exp_q[0];
          if (cyc == int'(o.cyc) + 1) begin
            ef = (o.kind == 2'b01) ? 3'b010 : (o.kind == 2'b10) ? 3'b001 : 3'b100;
            chk("issue_start", lru_start, 1);
            chk("issue_flags", {lru_found_in_cache, lru_updated, lru_replace}, ef);
            chk("issue_index", lru_index, o.idx);
            chk("issue_way", lru_way_index, o.way);
          end else begin
            chk("start_quiet", lru_start, 0);
          end
          if (cyc > int'(o.cyc) + 1 && cyc <= int'(o.cyc) + WAY + 2) begin
            chk("hold_index", lru_index, o.idx);
            chk("hold_way", lru_way_index, o.way);
          end
          if (cyc == int'(o.cyc) + OCC) begin
            em = '0;
            em[o.w] = 1'b1;
            if (o.kind == 2'b10) ew = eng_fired ? eng_victim + 5'd1 : 5'd0;
            else                 ew = o.way;
            chk("rsp_valid", rsp_valid, em);
            chk("rsp_way", rsp_way, ew);
            if (o.kind == 2'b10)      m_repls++;
            else if (o.kind == 2'b01) m_fills++;
            else                      m_hits++;
            void'(exp_q.pop_front());
          end else begin
            chk("rsp_quiet", rsp_valid, 0);
          end
        end else begin
          chk("start_quiet", lru_start, 0);
          chk("rsp_quiet", rsp_valid, 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int i, input logic [1:0] kind, input int idx, input int way);
    req_kind[2*i +: 2]    = kind;
    req_index[i*SIW +: SIW] = SIW'(idx);
    req_way[5*i +: 5]     = 5'(way);
    req[i] = 1'b1;
  endtask

  task automatic wait_rsp(input int i, output logic [4:0] got);
    bit seen = 1'b0;
    got = '0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (rsp_valid[i]) begin
        seen = 1'b1;
        got  = rsp_way;
      end
    end
    req[i] = 1'b0;
    chk("rsp_seen", seen, 1);
  endtask

  task automatic issue(input int i, input logic [1:0] kind, input int idx, input int way,
                       output logic [4:0] got);
    @(posedge clk);
    #1;
    drive(i, kind, idx, way);
    wait_rsp(i, got);
  endtask

  task automatic issue_rand(input int i);
    logic [4:0] got;
    repeat ($urandom_range(0, 3)) @(posedge clk);
    issue(i, 2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(1, WAY), got);
  endtask

  task automatic issue_drop(input int i, input logic [1:0] kind, input int idx, input int way);
    bit seen = 1'b0;
    logic [4:0] got;
    @(posedge clk);
    #1;
    drive(i, kind, idx, way);
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (gnt[i]) seen = 1'b1;
    end
    chk("drop_gnt_seen", seen, 1);
    @(posedge clk);
    #1;
    req[i] = 1'b0;
    wait_rsp(i, got);
    chk("drop_rsp_way", got, 5'(way));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] got, g0, g1, g2, g3;
    logic [N-1:0] mask;
    int k, nrsp;
    bit seen;
    rst = 1'b1;
    req = '0; req_kind = '0; req_index = '0; req_way = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single hit from requester 1
    issue(1, 2'b00, 5, 3, got);
    chk("hit_way", got, 3);

    // two replaces on a fresh set
    issue(2, 2'b10, 7, 1, got);
    chk("set7_first", got, 1);
    issue(2, 2'b10, 7, 1, got);
    chk("set7_second", got, 2);

    // one-cycle reset, request held from the first cycle after it
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 2'b00, 3, 2);
    k = 0; seen = 1'b0;
    while (!seen && k < 50) begin
      @(negedge clk);
      if (gnt[0]) seen = 1'b1;
      else k++;
    end
    chk("drain_len", k, WAY + 2);
    wait_rsp(0, got);
    chk("drain_hit_way", got, 2);

    // all four at once straight from reset
    pulse_reset();
    gnt_log.delete(); gnt_cyc_log.delete();
    fork
      issue(0, 2'b00, 11, 1, g0);
      issue(1, 2'b01, 12, 2, g1);
      issue(2, 2'b11, 13, 3, g2);
      issue(3, 2'b00, 14, 4, g3);
    join
    chk("rr4_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("rr4_order", gnt_log[i], i);
      for (int i = 1; i < 4; i++) chk("rr4_spacing", gnt_cyc_log[i] - gnt_cyc_log[i-1], WAY + 4);
    end
    chk("rr4_way3", g2, 3);

    // wrap: requesters 2 and 0 together
    gnt_log.delete();
    fork
      issue(2, 2'b00, 20, 2, g2);
      issue(0, 2'b00, 21, 4, g0);
    join
    chk("wrap_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("wrap_first", gnt_log[0], 0);
      chk("wrap_second", gnt_log[1], 2);
    end

    // request withdrawn after grant still completes
    issue_drop(3, 2'b01, 30, 3);

    // replace with no victim pulse reports way 0
    eng_mute = 1'b1;
    issue(1, 2'b10, 40, 1, got);
    chk("no_victim_way", got, 0);
    eng_mute = 1'b0;

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      fork
        begin if (mask[0]) issue_rand(0); end
        begin if (mask[1]) issue_rand(1); end
        begin if (mask[2]) issue_rand(2); end
        begin if (mask[3]) issue_rand(3); end
      join
    end

    // reset while a replace is in WAIT
    @(posedge clk);
    #1 drive(1, 2'b10, 9, 1);
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (gnt[1]) seen = 1'b1;
    end
    chk("mid_gnt_seen", seen, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    req[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    nrsp = 0;
    repeat (2 * WAY + 6) begin
      @(negedge clk);
      if (rsp_valid != '0) nrsp++;
    end
    chk("no_rsp_after_rst", nrsp, 0);
    issue(1, 2'b00, 9, 2, got);
    chk("post_rst_hit_way", got, 2);

    // mix for the counters: 2 hits, 1 fill, 3 replaces since the last reset
    issue(0, 2'b00, 50, 1, got);
    issue(2, 2'b01, 51, 2, got);
    chk("fill_way", got, 2);
    issue(3, 2'b10, 52, 1, got);
    issue(0, 2'b10, 52, 1, got);
    issue(1, 2'b10, 52, 1, got);
    chk("set52_third", got, 3);
    repeat (3) @(posedge clk);
    chk("model_hits", m_hits, 2);
    chk("model_fills", m_fills, 1);
    chk("model_repls", m_repls, 3);
`ifdef LRU_ARB_STATS_EN
    chk("hit_cnt", hit_cnt, 2);
    chk("fill_cnt", fill_cnt, 1);
    chk("repl_cnt", repl_cnt, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
